// File: rtl/perceptron_predictor.sv
// Perceptron branch predictor: one-cycle lookup over a global history register,
// table zeroing after reset, and a three-state read/train/write update engine.
module perceptron_predictor #(
  parameter int NUM_ENTRIES = 64,
  parameter int HIST_LEN    = 12,
  parameter int WEIGHT_W    = 8,
  parameter int THETA       = (193 * HIST_LEN) / 100 + 14,
  localparam int IDX_W      = $clog2(NUM_ENTRIES),
  localparam int SUM_W      = WEIGHT_W + $clog2(HIST_LEN + 1) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    init_done,
  input  logic                    lookup_valid,
  input  logic [31:0]             lookup_pc,
  input  logic                    stall,
  output logic                    pred_valid,
  output logic                    pred_dir,
  output logic signed [SUM_W-1:0] pred_sum,
  output logic [HIST_LEN-1:0]     pred_ghr,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [31:0]             upd_pc,
  input  logic                    upd_dir,
  input  logic signed [SUM_W-1:0] upd_sum,
  input  logic [HIST_LEN-1:0]     upd_ghr,
  input  logic                    upd_mispred
);

  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic signed [SUM_W-1:0]    sum_t;
  typedef enum logic {INIT, RUN} state_e;
  typedef enum logic [1:0] {U_IDLE, U_READ, U_WRITE} ustate_e;

  localparam weight_t W_MAX = weight_t'(2 ** (WEIGHT_W - 1) - 1);
  localparam weight_t W_MIN = -W_MAX;
  localparam weight_t W_ONE = weight_t'(1);
  localparam logic [SUM_W-1:0] THETA_U = SUM_W'(THETA);

  // Symmetric saturation keeps the most-negative code out of the table.
  function automatic weight_t sat_step(input weight_t w, input logic up);
    if (up) return (w >= W_MAX) ? W_MAX : w + W_ONE;
    return (w <= W_MIN) ? W_MIN : w - W_ONE;
  endfunction

  function automatic sum_t widen(input weight_t w);
    return {{(SUM_W - WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  weight_t             wt_q [NUM_ENTRIES][HIST_LEN+1];
  state_e              state_q;
  ustate_e             ustate_q;
  logic [IDX_W-1:0]    init_cnt_q;
  logic                init_done_q;
  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic                pred_valid_q, pred_dir_q;
  sum_t                pred_sum_q;
  logic [HIST_LEN-1:0] pred_ghr_q;

  logic [IDX_W-1:0]    u_idx_q;
  logic                u_dir_q, u_train_q;
  logic [HIST_LEN-1:0] u_ghr_q;
  weight_t             u_row_q [HIST_LEN+1];
  weight_t             tr_row  [HIST_LEN+1];

  logic [IDX_W-1:0]    lk_idx, wr_idx;
  sum_t                lk_sum;
  logic                lk_dir, lk_acc, upd_acc, restore, run, wr_en;
  logic [SUM_W-1:0]    upd_mag;
  weight_t             wr_row [HIST_LEN+1];
  logic                unused_pc_bits;

  assign run       = (state_q == RUN);
  assign upd_ready = run && (ustate_q == U_IDLE);
  assign upd_acc   = upd_valid && upd_ready;
  assign restore   = upd_acc && upd_mispred;
  assign lk_acc    = lookup_valid && !stall && run;
  assign lk_idx    = lookup_pc[IDX_W+1:2];
  assign lk_dir    = ~lk_sum[SUM_W-1];
  assign upd_mag   = upd_sum[SUM_W-1] ? $unsigned(-upd_sum) : $unsigned(upd_sum);
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

  assign init_done  = init_done_q;
  assign pred_valid = pred_valid_q;
  assign pred_dir   = pred_dir_q;
  assign pred_sum   = pred_sum_q;
  assign pred_ghr   = pred_ghr_q;

  always_comb begin
    lk_sum = widen(wt_q[lk_idx][0]);
    for (int i = 0; i < HIST_LEN; i++)
      lk_sum = ghr_q[i] ? lk_sum + widen(wt_q[lk_idx][i+1])
                        : lk_sum - widen(wt_q[lk_idx][i+1]);
  end

  // A mispredict restore wins over the speculative shift of a same-cycle lookup.
  always_comb begin
    ghr_d = ghr_q;
    if (restore)
      ghr_d = {upd_ghr[HIST_LEN-2:0], upd_dir};
    else if (lk_acc)
      ghr_d = {ghr_q[HIST_LEN-2:0], lk_dir};
  end

  always_comb begin
    tr_row[0] = sat_step(u_row_q[0], u_dir_q);
    for (int i = 0; i < HIST_LEN; i++)
      tr_row[i+1] = sat_step(u_row_q[i+1], u_dir_q == u_ghr_q[i]);
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = init_cnt_q;
    for (int j = 0; j <= HIST_LEN; j++) wr_row[j] = '0;
    if (state_q == INIT) begin
      wr_en = 1'b1;
    end else if (ustate_q == U_WRITE && u_train_q) begin
      wr_en  = 1'b1;
      wr_idx = u_idx_q;
      for (int j = 0; j <= HIST_LEN; j++) wr_row[j] = tr_row[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      ustate_q     <= U_IDLE;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_dir_q   <= 1'b0;
      pred_sum_q   <= '0;
      pred_ghr_q   <= '0;
    end else begin
      if (state_q == INIT) begin
        init_cnt_q <= init_cnt_q + IDX_W'(1);
        if (init_cnt_q == IDX_W'(NUM_ENTRIES - 1)) begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
      end

      case (ustate_q)
        U_IDLE:  if (upd_acc) ustate_q <= U_READ;
        U_READ:  ustate_q <= U_WRITE;
        default: ustate_q <= U_IDLE;
      endcase

      if (restore || !stall) ghr_q <= ghr_d;

      if (restore) begin
        pred_valid_q <= 1'b0;
      end else if (!stall) begin
        pred_valid_q <= lk_acc;
        if (lk_acc) begin
          pred_dir_q <= lk_dir;
          pred_sum_q <= lk_sum;
          pred_ghr_q <= ghr_q;
        end
      end
    end
  end

  // Table and update-capture registers carry no reset; INIT rewrites every row.
  always_ff @(posedge clk) begin
    if (upd_acc) begin
      u_idx_q   <= upd_pc[IDX_W+1:2];
      u_dir_q   <= upd_dir;
      u_ghr_q   <= upd_ghr;
      u_train_q <= upd_mispred || (upd_mag <= THETA_U);
    end
    if (ustate_q == U_READ)
      for (int j = 0; j <= HIST_LEN; j++) u_row_q[j] <= wt_q[u_idx_q][j];
    if (wr_en && !reset)
      for (int j = 0; j <= HIST_LEN; j++) wt_q[wr_idx][j] <= wr_row[j];
  end

endmodule

// File: tb/tb_perceptron_predictor.sv
// Directed bench for perceptron_predictor: init timing, lookup sums, training,
// threshold, saturation, stall, mispredict restore, bypass ordering and reset.
module tb_perceptron_predictor;
  localparam int HL = 12;
  localparam int SW = 13;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 init_done;
  logic                 lookup_valid = 1'b0;
  logic [31:0]          lookup_pc = '0;
  logic                 stall = 1'b0;
  logic                 pred_valid, pred_dir;
  logic signed [SW-1:0] pred_sum;
  logic [HL-1:0]        pred_ghr;
  logic                 upd_valid = 1'b0;
  logic                 upd_ready;
  logic [31:0]          upd_pc = '0;
  logic                 upd_dir = 1'b0;
  logic signed [SW-1:0] upd_sum = '0;
  logic [HL-1:0]        upd_ghr = '0;
  logic                 upd_mispred = 1'b0;

  int total = 0;
  int bad   = 0;

  perceptron_predictor dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .stall(stall),
    .pred_valid(pred_valid), .pred_dir(pred_dir), .pred_sum(pred_sum), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_dir(upd_dir),
    .upd_sum(upd_sum), .upd_ghr(upd_ghr), .upd_mispred(upd_mispred)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, 64);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!upd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!upd_ready) check("upd_ready_timeout", int'(upd_ready), 1);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic dir, input int sum,
                         input logic [HL-1:0] ghr, input logic mis);
    upd_pc = pc; upd_dir = dir; upd_sum = SW'(sum); upd_ghr = ghr; upd_mispred = mis;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic dir, input int sum,
                        input logic [HL-1:0] ghr, input logic mis);
    wait_ready();
    set_upd(pc, dir, sum, ghr, mis);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    wait_ready();
  endtask

  task automatic lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    check("rst_init_done", int'(init_done), 0);
    check("rst_pred_valid", int'(pred_valid), 0);
    check("rst_upd_ready", int'(upd_ready), 0);
    reset = 1'b0;
    wait_init("init_len");
    check("ready_after_init", int'(upd_ready), 1);

    // Zeroed table: sum 0 predicts taken; history shifts in the taken bit.
    lookup_valid = 1'b1; lookup_pc = 32'h0;
    tick();
    check("lk0_valid", int'(pred_valid), 1);
    check("lk0_sum", int'(pred_sum), 0);
    check("lk0_dir", int'(pred_dir), 1);
    check("lk0_ghr", int'(pred_ghr), 0);
    tick();
    check("ghr_shift", int'(pred_ghr), 1);
    stall = 1'b1;
    tick();
    check("stall_pv_hold", int'(pred_valid), 1);
    check("stall_ghr_hold", int'(pred_ghr), 1);
    stall = 1'b0;
    tick();
    check("after_stall_ghr", int'(pred_ghr), 3);
    lookup_valid = 1'b0;
    tick();
    check("pv_drop", int'(pred_valid), 0);

    // Five not-taken mispredicts on row 4; first one checks 1-per-3 throughput.
    set_upd(32'h10, 1'b0, 0, 12'h000, 1'b1);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    check("ready_busy1", int'(upd_ready), 0);
    tick();
    check("ready_busy2", int'(upd_ready), 0);
    tick();
    check("ready_back", int'(upd_ready), 1);
    repeat (4) do_upd(32'h10, 1'b0, 0, 12'h000, 1'b1);
    lookup(32'h10);
    check("train5_sum", int'(pred_sum), -65);
    check("train5_dir", int'(pred_dir), 0);

    // Threshold boundary: |sum| 38 skips training, 37 trains.
    do_upd(32'h10, 1'b0, 38, 12'h000, 1'b0);
    lookup(32'h10);
    check("theta38_nochange", int'(pred_sum), -65);
    do_upd(32'h10, 1'b0, 37, 12'h000, 1'b0);
    lookup(32'h10);
    check("theta37_train", int'(pred_sum), -78);

    // Lookup coinciding with the write of the same row sees old weights.
    wait_ready();
    set_upd(32'h10, 1'b0, 0, 12'h000, 1'b0);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    tick();
    lookup_valid = 1'b1; lookup_pc = 32'h10;
    tick();
    check("same_row_prewrite", int'(pred_sum), -78);
    tick();
    check("same_row_postwrite", int'(pred_sum), -91);
    lookup_valid = 1'b0;
    do_upd(32'h10, 1'b0, -38, 12'h000, 1'b0);
    lookup(32'h10);
    check("theta_neg38_nochange", int'(pred_sum), -91);

    // Positive saturation on row 8.
    repeat (200) do_upd(32'h20, 1'b1, 0, 12'hFFF, 1'b1);
    lookup(32'h20);
    check("sat_pos_sum", int'(pred_sum), 1651);
    check("sat_pos_ghr", int'(pred_ghr), 12'hFFF);
    do_upd(32'h20, 1'b1, 0, 12'hFFF, 1'b1);
    lookup(32'h20);
    check("sat_pos_hold", int'(pred_sum), 1651);

    // Negative saturation on row 12 stops at -127, never -128.
    repeat (200) do_upd(32'h30, 1'b0, 0, 12'hFFF, 1'b1);
    lookup(32'h30);
    check("sat_neg_sum", int'(pred_sum), -1397);
    check("sat_neg_dir", int'(pred_dir), 0);
    check("sat_neg_ghr", int'(pred_ghr), 12'hFFE);

    // Mispredict restore beats a simultaneous lookup.
    wait_ready();
    set_upd(32'h40, 1'b1, 0, 12'hABC, 1'b1);
    upd_valid = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h0;
    tick();
    upd_valid = 1'b0;
    lookup_valid = 1'b0;
    check("restore_pv0", int'(pred_valid), 0);
    lookup(32'h0);
    check("restore_ghr", int'(pred_ghr), 12'h579);
    check("restore_next_pv", int'(pred_valid), 1);

    // Reset during U_READ, then again mid-INIT.
    wait_ready();
    set_upd(32'h10, 1'b1, 0, 12'h000, 1'b0);
    upd_valid = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h10;
    tick();
    upd_valid = 1'b0;
    lookup_valid = 1'b0;
    check("pre_rst_pv", int'(pred_valid), 1);
    check("pre_rst_sum", int'(pred_sum), 21);
    #2 reset = 1'b1;
    #1;
    check("rst_async_init_done", int'(init_done), 0);
    check("rst_async_pv", int'(pred_valid), 0);
    check("rst_async_dir", int'(pred_dir), 0);
    check("rst_async_sum", int'(pred_sum), 0);
    check("rst_async_ghr", int'(pred_ghr), 0);
    check("rst_async_ready", int'(upd_ready), 0);
    tick(); tick();
    reset = 1'b0;
    repeat (30) tick();
    #2 reset = 1'b1;
    #1;
    check("rst_midinit_done", int'(init_done), 0);
    check("rst_midinit_ready", int'(upd_ready), 0);
    tick();
    reset = 1'b0;
    wait_init("reinit_len");
    lookup(32'h10);
    check("reinit_row4_sum", int'(pred_sum), 0);
    check("reinit_ghr", int'(pred_ghr), 0);
    check("reinit_dir", int'(pred_dir), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
